// File: rtl/mips_div_iter_pkg.sv
// ---------------------------------------------------------------------------
// mips_div_iter_pkg
//   Shared definitions for the iterative DIV/DIVU unit: FSM state codes and
//   the nominal handshake latencies seen by the EXE stage.
// ---------------------------------------------------------------------------
package mips_div_iter_pkg;

  // 2-bit state encoding of the divider FSM.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

  // Cycles from the first start cycle in IDLE to ready for a 32-bit divide.
  localparam int DIV_LAT      = 33;
  // Same measure for a divide-by-zero request.
  localparam int DIV_ZERO_LAT = 2;

endpackage

// File: rtl/mips_div_iter_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One restoring-division iteration, purely combinational.
//   Shifts {rem_in, quo_in} left by one bit, then trial-subtracts the
//   divisor from the widened partial remainder; on success the remainder is
//   replaced by the difference and a 1 enters the quotient LSB.
// Ports
//   rem_in   in  DATA_W  partial remainder before this iteration
//   quo_in   in  DATA_W  dividend bits still to consume / quotient so far
//   divisor  in  DATA_W  divisor magnitude (non-zero)
//   rem_out  out DATA_W  partial remainder after this iteration
//   quo_out  out DATA_W  shifted quotient with the new bit in the LSB
// ---------------------------------------------------------------------------
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  // rem_in < divisor <= 2^DATA_W-1, so 2*rem_in+1 needs one extra bit.
  logic [DATA_W:0] rem_shift;
  logic [DATA_W:0] diff;
  logic            fits;
  logic            unused_diff_msb;

  always_comb begin
    rem_shift = {rem_in, quo_in[DATA_W-1]};
    diff      = rem_shift - {1'b0, divisor};
    fits      = (rem_shift >= {1'b0, divisor});
    if (fits) begin
      rem_out = diff[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end else begin
      rem_out = rem_shift[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end
  end

  // When the subtraction is taken the difference is below the divisor, so
  // its top bit is always zero and is deliberately dropped.
  assign unused_diff_msb = diff[DATA_W];

endmodule

// File: rtl/mips_div_iter.sv
// ---------------------------------------------------------------------------
// mips_div_iter
//   Iterative restoring divider for DIV/DIVU, responder side of the EXE
//   start/ready handshake. One quotient bit per cycle on operand magnitudes,
//   signs applied when the result is registered.
// Ports
//   clk           in   1         clock, rising edge
//   reset         in   1         asynchronous active-high reset
//   signed_div_i  in   1         1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     in   DATA_W    dividend, sampled with start_i in IDLE
//   opdata2_i     in   DATA_W    divisor, sampled with start_i in IDLE
//   start_i       in   1         request, held until ready_o is seen
//   annul_i       in   1         abort the operation in flight
//   result_o      out  2*DATA_W  {remainder, quotient}, valid with ready_o
//   ready_o       out  1         result valid (END state)
// ---------------------------------------------------------------------------
module mips_div_iter
  import mips_div_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};

  // Two's complement negation when en is set; also used as |x| on entry.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              en);
    return en ? (~v + ONE) : v;
  endfunction

  div_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] dividend_q;
  logic              neg_quo_q;
  logic              neg_rem_q;

  logic              op1_neg;
  logic              op2_neg;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];

  div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= DIV_IDLE;
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      case (state)
        // ---- accept: latch magnitudes and sign decisions -------------------
        DIV_IDLE: begin
          if (start_i && !annul_i) begin
            dividend_q <= opdata1_i;
            rem_q      <= '0;
            quo_q      <= neg_if(opdata1_i, op1_neg);
            divisor_q  <= neg_if(opdata2_i, op2_neg);
            // Quotient sign follows both operands, remainder sign the dividend.
            neg_quo_q  <= op1_neg ^ op2_neg;
            neg_rem_q  <= op1_neg;
            cnt        <= '0;
            state      <= (opdata2_i == '0) ? DIV_ZERO : DIV_ON;
          end
        end

        // ---- divide by zero: fixed result after one cycle ------------------
        DIV_ZERO: begin
          if (annul_i) begin
            state <= DIV_IDLE;
          end else begin
            result_o <= {dividend_q, {DATA_W{1'b1}}};
            ready_o  <= 1'b1;
            state    <= DIV_END;
          end
        end

        // ---- iterate: one restoring step per cycle -------------------------
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_IDLE;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (cnt == CNT_LAST) begin
              // Final step result goes straight through the sign fix-up.
              result_o <= {neg_if(rem_nxt, neg_rem_q), neg_if(quo_nxt, neg_quo_q)};
              ready_o  <= 1'b1;
              state    <= DIV_END;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end

        // ---- present result until the initiator releases start -------------
        DIV_END: begin
          if (annul_i || !start_i) begin
            ready_o <= 1'b0;
            state   <= DIV_IDLE;
          end
        end

        default: begin
          ready_o <= 1'b0;
          state   <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_iter.sv
// ---------------------------------------------------------------------------
// tb_mips_div_iter
//   Self-checking bench for mips_div_iter: vector table plus hand-written
//   sequences for annul, reset and back-to-back handshakes. Expected results
//   are queued when a request is driven and popped when ready_o appears.
// ---------------------------------------------------------------------------
module tb_mips_div_iter;

  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          signed_div_i;
  logic [DW-1:0] opdata1_i;
  logic [DW-1:0] opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*DW-1:0] result_o;
  logic          ready_o;

  mips_div_iter #(.DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc_count = 0;
  int unsigned last_ready_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_count <= cyc_count + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Reference quotient/remainder with 64-bit host arithmetic (truncating
  // division, remainder takes the dividend's sign).
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    if (sgn) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sbv = longint'({32'd0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one request at the current negedge (cycle 0), scramble operands
  // once accepted, wait for ready, check latency/result, optionally hold
  // start in END, then release (or annul) and check ready drops.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input int hold,
                        input bit annul_end, input string nm);
    int          cyc;
    logic [63:0] want;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    sb.push_back(exp);
    cyc = 0;
    while (ready_o !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
    end
    last_ready_cyc = cyc_count;
    check({nm, " latency"}, 64'(cyc), 64'(lat));
    want = sb.pop_front();
    check({nm, " result"}, result_o, want);
    repeat (hold) begin
      @(negedge clk);
      check({nm, " hold ready"}, 64'(ready_o), 64'd1);
      check({nm, " hold result"}, result_o, want);
    end
    if (annul_end) annul_i = 1'b1;
    else           start_i = 1'b0;
    @(negedge clk);
    check({nm, " ready drop"}, 64'(ready_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
  endtask

  task automatic expect_silent(input int n, input string nm);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen++;
    end
    check(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    int unsigned t0;
    vec_t v;

    // Vector table: spec-listed corners plus modelled random operands.
    tbl.push_back('{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},          33, "divu_100_7"});
    tbl.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD},   33, "div_m7_2"});
    tbl.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1,          32'hFFFF_FFFD},   33, "div_7_m2"});
    tbl.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,          32'h8000_0000},   33, "div_ovf"});
    tbl.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0,          32'hFFFF_FFFF},   33, "divu_max_1"});
    tbl.push_back('{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0,          32'h1},           33, "divu_max_max"});
    tbl.push_back('{1'b0, 32'd5,          32'd9,          {32'd5,          32'd0},           33, "divu_small"});
    tbl.push_back('{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  {32'hFFFF_FFFE,  32'd2},           33, "div_m8_m3"});
    tbl.push_back('{1'b0, 32'h1234,       32'd0,          {32'h1234,       32'hFFFF_FFFF},   2,  "div0_u"});
    tbl.push_back('{1'b1, 32'hFFFF_FFF0,  32'd0,          {32'hFFFF_FFF0,  32'hFFFF_FFFF},   2,  "div0_s"});
    for (int i = 0; i < 6; i++) begin
      v.sgn = 1'($urandom_range(0, 1));
      v.a   = $urandom;
      v.b   = $urandom >> $urandom_range(0, 28);
      if (v.b == 32'd0) v.b = 32'd1;
      if (v.sgn && v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF) v.b = 32'd3;
      v.exp  = model(v.sgn, v.a, v.b);
      v.lat  = 33;
      v.name = $sformatf("rand%0d", i);
      tbl.push_back(v);
    end

    // Reset state (asynchronous, observed before any clock edge).
    reset        = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // DIVU 100/7 with start held a few cycles in END.
    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 3, 1'b0, "held_100_7");

    foreach (tbl[i])
      run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0, 1'b0, tbl[i].name);

    // annul while parked in END with start still high.
    run_op(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1, 1'b1, "annul_end");
    expect_silent(3, "annul_end quiet");

    // start together with annul in IDLE is refused.
    opdata1_i = 32'd77; opdata2_i = 32'd7; signed_div_i = 1'b0;
    start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    expect_silent(40, "start_annul_idle quiet");

    // annul pulse in cycle 10 of a division: no ready ever.
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    expect_silent(60, "annul_on quiet");
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0, 1'b0, "after_annul_9_3");

    // Asynchronous reset in cycle 15 of a division.
    opdata1_i = 32'd1000; opdata2_i = 32'd7; signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset ready", 64'(ready_o), 64'd0);
    check("midreset result", result_o, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    start_i = 1'b0;
    expect_silent(40, "midreset quiet");
    run_op(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 0, 1'b0, "after_reset");

    // Back-to-back: second start in the cycle after ready drops.
    t0 = cyc_count;
    run_op(1'b0, 32'd200, 32'd7, {32'd4, 32'd28}, 33, 0, 1'b0, "b2b_first");
    run_op(1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 33, 0, 1'b0, "b2b_second");
    check("b2b second ready cycle", 64'(last_ready_cyc - t0), 64'd67);

    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
